stack_arbiter: RTL and testbench
================================

# stack_arbiter

Two-port arbiter and sequencer in front of the shared LIFO `stack` block (ports Clk, RstN, Data_In, Push, Pop, Data_Out, Full, Empty). It accepts push/pop requests from two independent requesters (A and B) and grants them round-robin. It issues exactly one stack operation per granted request and returns a completion pulse, with pop data, to the winning requester. Requests that would overflow or underflow the stack are rejected with an error pulse and never reach the stack.

## Interface
- STACK_WIDTH, 4, data width, matching the stack's STACK_WIDTH.
- Clk  in  1  clock; all logic on the rising edge.
- Rst  in  1  synchronous, active-high reset.
- Req_A / Req_B  in  1  request valid; held high until the matching Done or Err pulse.
- Op_A / Op_B  in  1  0 = push, 1 = pop; stable while Req is high.
- Wdata_A / Wdata_B  in  STACK_WIDTH  push data; stable while Req is high.
- Done_A / Done_B  out  1  one-cycle completion pulse.
- Err_A / Err_B  out  1  one-cycle reject pulse (push when Full, or pop when Empty).
- Rdata_A / Rdata_B  out  STACK_WIDTH  pop result; valid only while Done_x is high and Op = pop.
- Stk_Push, Stk_Pop  out  1  drive stack Push/Pop.
- Stk_Data_In  out  STACK_WIDTH  drives stack Data_In.
- Stk_Data_Out  in  STACK_WIDTH  from stack Data_Out.
- Stk_Full, Stk_Empty  in  1  from stack.

## Operation
- Three-state FSM: IDLE, ISSUE, RESP.
- IDLE
  - No request: stay in IDLE.
  - Otherwise pick a winner:
    - Only one requester active: that requester wins.
    - Both active: the requester not served last wins.
  - Register the winner's id, Op and Wdata.
  - Legality check against Stk_Full / Stk_Empty sampled this cycle:
    - Legal: go to ISSUE.
    - Illegal (push && Full, or pop && Empty): go to RESP with the reject flag set.
- ISSUE: assert Stk_Push or Stk_Pop for exactly this one cycle; Stk_Data_In = latched Wdata. Go to RESP.
- RESP
  - Reject flag clear: pulse Done_winner. For a pop, Rdata_winner = Stk_Data_Out.
  - Reject flag set: pulse Err_winner instead.
  - Update the last-served pointer to the winner, then go to IDLE.
- Round-robin pointer
  - Reset value = B, so A wins the first tie.
  - Updated on both Done and Err.
- Never assert Stk_Push and Stk_Pop together. Never assert either outside ISSUE.
- Requester sequencing:
  - A requester that drops Req before being selected is simply not served.
  - After selection, the latched copy is used, so changes on Req, Op or Wdata are ignored.
  - The requester must deassert Req or present a new request the cycle after Done/Err. Req still high in IDLE is treated as a new request.
- Reset, at any state, takes effect on the next edge:
  - FSM goes to IDLE and the pointer to B.
  - All Done, Err and Stk_* strobes go to 0; Rdata_A/B and Stk_Data_In go to 0.
  - An in-flight operation is dropped, with no Done or Err.
  - The stack has its own RstN, driven separately by the system.

## Timing
- Legal op: Req seen in IDLE at cycle n → Stk_Push/Stk_Pop high during cycle n+1 → Done high in cycle n+2. Latency is 2 cycles; the stack updates Data_Out on the edge ending cycle n+1.
- Rejected op: Req at cycle n → Err high in cycle n+1, with no stack strobe.
- Throughput: one op per 3 cycles (legal) or per 2 cycles (reject). Back-to-back requests alternate A, B, A…
- Full/Empty are sampled only in IDLE. They cannot change mid-op because this block is the stack's sole driver.

## Structure
- Shared package `stack_pkg`:
  - STACK_WIDTH and STACK_DEPTH defaults.
  - FSM state encoding (IDLE=0, ISSUE=1, RESP=2).
  - Op encoding constants OP_PUSH=0, OP_POP=1.
- One natural sub-module, `rr_arb2`: the combinational 2-way round-robin pick plus its registered last-served pointer, with inputs req[1:0], update and winner. The FSM, latches and output pulses stay in `stack_arbiter`.
- The bench instantiates `stack_arbiter` together with the existing `stack` at depth 8 and width 4.

## Test plan
- Reset then single push: Req_A=1, Op_A=0, Wdata_A=5 → Stk_Push for 1 cycle with Stk_Data_In=5, Done_A 2 cycles after request, Empty goes 0.
- LIFO through arbiter: A pushes 1, 2, 3, then pops three times → Rdata_A = 3, 2, 1 on the three Done_A pulses.
- Contention: Req_A and Req_B both held (A pushes 7, B pushes 9) from reset → A served first, then B; a subsequent pop returns 9.
- Overflow: 8 pushes of 0..7 (Full=1), then ninth push of 11 → Err pulse 1 cycle after request, no Stk_Push, and the next pop returns 7.
- Underflow: pop on an empty stack → Err, no Stk_Pop. A pop request from B alongside a push from A on the same empty stack → A served first (push), then B's pop returns A's data.
- Reset mid-op: assert Rst during ISSUE → next cycle all outputs 0 and FSM in IDLE; with both requests held, A is granted first afterward.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared definitions for the stack arbiter: widths, FSM state encoding,
// push/pop op codes and the requester ids used by the round-robin picker.
package stack_pkg;

   localparam int STACK_WIDTH = 4;
   localparam int STACK_DEPTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2
   } state_t;

   localparam logic OP_PUSH = 1'b0;
   localparam logic OP_POP  = 1'b1;

   localparam logic ID_A = 1'b0;
   localparam logic ID_B = 1'b1;

   // A push into a full stack or a pop from an empty one is rejected.
   function automatic logic is_illegal(input logic op, input logic full, input logic empty);
      return ((op == OP_PUSH) && full) || ((op == OP_POP) && empty);
   endfunction

endpackage

// File: rtl/stack_arbiter_rr_arb2.sv
// Two-way round-robin picker: combinational grant from the request pair,
// registered last-served pointer that favours the other side on a tie.
module rr_arb2 (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [1:0] i_req,
   input  logic       i_update,
   input  logic       i_winner,
   output logic       o_grant
);
   import stack_pkg::*;

   logic r_last;

   // Pointer starts at B so that A wins the first tie after reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_last <= ID_B;
      end else if (i_update) begin
         r_last <= i_winner;
      end
   end

   always_comb begin
      o_grant = ID_A;
      if (i_req == 2'b10) begin
         o_grant = ID_B;
      end else if (i_req == 2'b11) begin
         o_grant = ~r_last;
      end
   end

endmodule

// File: rtl/stack_arbiter.sv
// Two-requester arbiter/sequencer in front of a shared LIFO stack: one stack
// strobe per granted request, Done/Err pulse and pop data back to the winner.
//
// Handshake: Req_x is a valid that stays high (with Op_x/Wdata_x stable) until
// Done_x or Err_x pulses for one cycle; the requester then drops Req_x or
// presents a new request, since Req_x seen high in IDLE is a fresh request.
module stack_arbiter #(
   parameter int STACK_WIDTH = stack_pkg::STACK_WIDTH
) (
   input  logic                   Clk,
   input  logic                   Rst,
   input  logic                   Req_A,
   input  logic                   Op_A,
   input  logic [STACK_WIDTH-1:0] Wdata_A,
   input  logic                   Req_B,
   input  logic                   Op_B,
   input  logic [STACK_WIDTH-1:0] Wdata_B,
   output logic                   Done_A,
   output logic                   Done_B,
   output logic                   Err_A,
   output logic                   Err_B,
   output logic [STACK_WIDTH-1:0] Rdata_A,
   output logic [STACK_WIDTH-1:0] Rdata_B,
   output logic                   Stk_Push,
   output logic                   Stk_Pop,
   output logic [STACK_WIDTH-1:0] Stk_Data_In,
   input  logic [STACK_WIDTH-1:0] Stk_Data_Out,
   input  logic                   Stk_Full,
   input  logic                   Stk_Empty,
   output logic [1:0]             Dbg_State
);
   import stack_pkg::*;

   state_t                 r_state;
   state_t                 w_next;
   logic                   r_id;
   logic                   r_op;
   logic                   r_rej;
   logic [STACK_WIDTH-1:0] r_wdata;

   logic                   w_any;
   logic                   w_grant;
   logic                   w_op;
   logic                   w_rej;
   logic                   w_update;
   logic [STACK_WIDTH-1:0] w_wdata;

   assign w_any    = Req_A | Req_B;
   assign w_op     = (w_grant == ID_B) ? Op_B : Op_A;
   assign w_wdata  = (w_grant == ID_B) ? Wdata_B : Wdata_A;
   assign w_rej    = is_illegal(w_op, Stk_Full, Stk_Empty);
   assign w_update = (r_state == ST_RESP);

   rr_arb2 u_rr (
      .i_clk    (Clk),
      .i_rst    (Rst),
      .i_req    ({Req_B, Req_A}),
      .i_update (w_update),
      .i_winner (r_id),
      .o_grant  (w_grant)
   );

   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Rejected requests skip ISSUE so the stack never sees them.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:  if (w_any) w_next = w_rej ? ST_RESP : ST_ISSUE;
         ST_ISSUE: w_next = ST_RESP;
         ST_RESP:  w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   // Winner and its request are frozen here; later changes on Req/Op/Wdata are ignored.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_id    <= ID_A;
         r_op    <= OP_PUSH;
         r_rej   <= 1'b0;
         r_wdata <= '0;
      end else if ((r_state == ST_IDLE) && w_any) begin
         r_id    <= w_grant;
         r_op    <= w_op;
         r_rej   <= w_rej;
         r_wdata <= w_wdata;
      end
   end

   always_comb begin
      Done_A      = 1'b0;
      Done_B      = 1'b0;
      Err_A       = 1'b0;
      Err_B       = 1'b0;
      Rdata_A     = '0;
      Rdata_B     = '0;
      Stk_Push    = 1'b0;
      Stk_Pop     = 1'b0;
      Stk_Data_In = '0;
      case (r_state)
         ST_ISSUE: begin
            Stk_Push    = (r_op == OP_PUSH);
            Stk_Pop     = (r_op == OP_POP);
            Stk_Data_In = r_wdata;
         end
         ST_RESP: begin
            Done_A = ~r_rej & (r_id == ID_A);
            Done_B = ~r_rej & (r_id == ID_B);
            Err_A  = r_rej & (r_id == ID_A);
            Err_B  = r_rej & (r_id == ID_B);
            if (~r_rej && (r_op == OP_POP)) begin
               if (r_id == ID_A) Rdata_A = Stk_Data_Out;
               else              Rdata_B = Stk_Data_Out;
            end
         end
         default: ;
      endcase
   end

   assign Dbg_State = r_state;

endmodule

// File: tb/tb_stack_arbiter.sv
// Bench for stack_arbiter: a small behavioural depth-8 stack on the stack
// ports, table-driven plan rows, a reset-during-ISSUE sequence, random traffic.
module tb_stack_arbiter;

   localparam int W     = 4;
   localparam int DEPTH = 8;

   logic         Clk = 1'b0;
   logic         Rst = 1'b1;
   logic         Req_A = 1'b0, Op_A = 1'b0, Req_B = 1'b0, Op_B = 1'b0;
   logic [W-1:0] Wdata_A = '0, Wdata_B = '0;
   logic         Done_A, Done_B, Err_A, Err_B, Stk_Push, Stk_Pop, Stk_Full, Stk_Empty;
   logic [W-1:0] Rdata_A, Rdata_B, Stk_Data_In, Stk_Data_Out;
   logic [1:0]   Dbg_State;

   int total = 0;
   int bad   = 0;

   stack_arbiter #(.STACK_WIDTH(W)) dut (
      .Clk(Clk), .Rst(Rst),
      .Req_A(Req_A), .Op_A(Op_A), .Wdata_A(Wdata_A),
      .Req_B(Req_B), .Op_B(Op_B), .Wdata_B(Wdata_B),
      .Done_A(Done_A), .Done_B(Done_B), .Err_A(Err_A), .Err_B(Err_B),
      .Rdata_A(Rdata_A), .Rdata_B(Rdata_B),
      .Stk_Push(Stk_Push), .Stk_Pop(Stk_Pop), .Stk_Data_In(Stk_Data_In),
      .Stk_Data_Out(Stk_Data_Out), .Stk_Full(Stk_Full), .Stk_Empty(Stk_Empty),
      .Dbg_State(Dbg_State)
   );

   always #5 Clk = ~Clk;

   // ---------------- behavioural stack on the stack ports ----------------
   logic         stk_rstn = 1'b0;
   logic [W-1:0] s_mem [DEPTH];
   int           s_cnt = 0;
   logic [W-1:0] s_dout = '0;

   assign Stk_Full     = (s_cnt == DEPTH);
   assign Stk_Empty    = (s_cnt == 0);
   assign Stk_Data_Out = s_dout;

   always @(posedge Clk) begin
      if (!stk_rstn) begin
         s_cnt  <= 0;
         s_dout <= '0;
      end else if (Stk_Push && s_cnt < DEPTH) begin
         s_mem[s_cnt] <= Stk_Data_In;
         s_cnt        <= s_cnt + 1;
      end else if (Stk_Pop && s_cnt > 0) begin
         s_dout <= s_mem[s_cnt-1];
         s_cnt  <= s_cnt - 1;
      end
   end

   // ---------------- transaction-level reference model ----------------
   logic [W-1:0] m_stk[$];
   bit           m_last = 1'b1;

   bit           obs_id  [2];
   bit           obs_err [2];
   logic [W-1:0] obs_rd  [2];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   always @(negedge Clk) begin
      if (stk_rstn) begin
         total++;
         if (Stk_Push && Stk_Pop) begin
            bad++;
            $display("FAIL strobe_overlap: push=%0b pop=%0b want not both", Stk_Push, Stk_Pop);
         end
      end
   end

   // Leaves the bench at posedge+1 of an IDLE cycle with the model emptied.
   task automatic do_reset();
      Req_A = 1'b0; Req_B = 1'b0; Rst = 1'b1; stk_rstn = 1'b0;
      repeat (2) @(posedge Clk);
      #1;
      Rst = 1'b0; stk_rstn = 1'b1;
      m_stk.delete();
      m_last = 1'b1;
      @(negedge Clk);
      chk("reset flags", {Dbg_State, Done_A, Done_B, Err_A, Err_B, Stk_Push, Stk_Pop}, 8'h00);
      chk("reset data", {Rdata_A, Rdata_B, Stk_Data_In}, 12'h000);
      @(posedge Clk); #1;
   endtask

   // Presents up to one request per side and follows every grant cycle by cycle.
   task automatic serve(input bit av, input bit aop, input logic [W-1:0] aw,
                        input bit bv, input bit bop, input logic [W-1:0] bw);
      bit pa, pb;
      pa = av; pb = bv;
      Req_A = av; Op_A = aop; Wdata_A = aw;
      Req_B = bv; Op_B = bop; Wdata_B = bw;
      for (int k = 0; k < 2; k++) begin
         bit           win, op, rej;
         logic [W-1:0] w, erd;
         obs_id[k] = 1'b0; obs_err[k] = 1'b0; obs_rd[k] = '0;
         if (pa || pb) begin
            win = (pa && pb) ? ~m_last : pb;
            op  = win ? bop : aop;
            w   = win ? bw : aw;
            rej = op ? (m_stk.size() == 0) : (m_stk.size() == DEPTH);
            erd = '0;
            if (!rej) begin
               if (op) erd = m_stk.pop_back();
               else    m_stk.push_back(w);
            end
            m_last = win;
            @(negedge Clk);
            chk("idle", {Dbg_State, Done_A, Done_B, Err_A, Err_B, Stk_Push, Stk_Pop}, 8'h00);
            if (!rej) begin
               @(negedge Clk);
               chk("issue", {Dbg_State, Done_A, Done_B, Err_A, Err_B, Stk_Push, Stk_Pop},
                   {2'd1, 4'b0000, ~op, op});
               chk("issue data", Stk_Data_In, w);
            end
            @(negedge Clk);
            chk("resp", {Dbg_State, Done_A, Done_B, Err_A, Err_B, Stk_Push, Stk_Pop},
                {2'd2, ~rej & ~win, ~rej & win, rej & ~win, rej & win, 2'b00});
            if (Done_A && aop)      obs_rd[k] = Rdata_A;
            else if (Done_B && bop) obs_rd[k] = Rdata_B;
            obs_id[k]  = Done_B | Err_B;
            obs_err[k] = Err_A | Err_B;
            if (!rej && op) chk("rdata", obs_rd[k], erd);
            @(posedge Clk); #1;
            if (win) begin Req_B = 1'b0; pb = 1'b0; end
            else     begin Req_A = 1'b0; pa = 1'b0; end
         end
      end
   endtask

   // ---------------- plan vectors ----------------
   typedef struct {
      bit           rst;
      bit           av, aop;
      logic [W-1:0] aw;
      bit           bv, bop;
      logic [W-1:0] bw;
      bit           e_first, e_err0;
      logic [W-1:0] e_rd0;
      bit           e_err1;
      logic [W-1:0] e_rd1;
   } vec_t;

   vec_t tab[$];

   function automatic vec_t mk(bit rst, bit av, bit aop, logic [W-1:0] aw,
                               bit bv, bit bop, logic [W-1:0] bw,
                               bit ef, bit ee0, logic [W-1:0] er0, bit ee1, logic [W-1:0] er1);
      vec_t v;
      v.rst = rst; v.av = av; v.aop = aop; v.aw = aw; v.bv = bv; v.bop = bop; v.bw = bw;
      v.e_first = ef; v.e_err0 = ee0; v.e_rd0 = er0; v.e_err1 = ee1; v.e_rd1 = er1;
      return v;
   endfunction

   initial begin
      // single push, then LIFO order through A
      tab.push_back(mk(1, 1, 0, 4'd5, 0, 0, 4'd0, 0, 0, 4'd0, 0, 4'd0));
      tab.push_back(mk(0, 1, 0, 4'd1, 0, 0, 4'd0, 0, 0, 4'd0, 0, 4'd0));
      tab.push_back(mk(0, 1, 0, 4'd2, 0, 0, 4'd0, 0, 0, 4'd0, 0, 4'd0));
      tab.push_back(mk(0, 1, 0, 4'd3, 0, 0, 4'd0, 0, 0, 4'd0, 0, 4'd0));
      tab.push_back(mk(0, 1, 1, 4'd0, 0, 0, 4'd0, 0, 0, 4'd3, 0, 4'd0));
      tab.push_back(mk(0, 1, 1, 4'd0, 0, 0, 4'd0, 0, 0, 4'd2, 0, 4'd0));
      tab.push_back(mk(0, 1, 1, 4'd0, 0, 0, 4'd0, 0, 0, 4'd1, 0, 4'd0));
      // contention from reset: A first, then B; pop sees B's 9
      tab.push_back(mk(1, 1, 0, 4'd7, 1, 0, 4'd9, 0, 0, 4'd0, 0, 4'd0));
      tab.push_back(mk(0, 1, 1, 4'd0, 0, 0, 4'd0, 0, 0, 4'd9, 0, 4'd0));
      // overflow: eight pushes fill the stack, ninth rejected, pop returns 7
      for (int i = 0; i < DEPTH; i++)
         tab.push_back(mk(i == 0, 1, 0, 4'(i), 0, 0, 4'd0, 0, 0, 4'd0, 0, 4'd0));
      tab.push_back(mk(0, 1, 0, 4'd11, 0, 0, 4'd0, 0, 1, 4'd0, 0, 4'd0));
      tab.push_back(mk(0, 1, 1, 4'd0, 0, 0, 4'd0, 0, 0, 4'd7, 0, 4'd0));
      // underflow by B, then A push races B pop on the empty stack
      tab.push_back(mk(1, 0, 0, 4'd0, 1, 1, 4'd0, 1, 1, 4'd0, 0, 4'd0));
      tab.push_back(mk(0, 1, 0, 4'd4, 1, 1, 4'd0, 0, 0, 4'd0, 0, 4'd4));

      foreach (tab[i]) begin
         if (tab[i].rst) do_reset();
         serve(tab[i].av, tab[i].aop, tab[i].aw, tab[i].bv, tab[i].bop, tab[i].bw);
         chk($sformatf("row%0d first", i), {31'd0, obs_id[0]}, {31'd0, tab[i].e_first});
         chk($sformatf("row%0d err0", i), {31'd0, obs_err[0]}, {31'd0, tab[i].e_err0});
         chk($sformatf("row%0d rd0", i), obs_rd[0], tab[i].e_rd0);
         if (tab[i].av && tab[i].bv) begin
            chk($sformatf("row%0d err1", i), {31'd0, obs_err[1]}, {31'd0, tab[i].e_err1});
            chk($sformatf("row%0d rd1", i), obs_rd[1], tab[i].e_rd1);
         end
      end

      // reset while B's op sits in ISSUE: op dropped, pointer back to B, A wins next tie
      do_reset();
      serve(1, 0, 4'd3, 0, 0, 4'd0);
      Req_A = 1'b1; Op_A = 1'b0; Wdata_A = 4'd6;
      Req_B = 1'b1; Op_B = 1'b0; Wdata_B = 4'd8;
      @(negedge Clk);
      @(negedge Clk);
      chk("midrst issue", {Dbg_State, Stk_Push, Stk_Data_In}, {2'd1, 1'b1, 4'd8});
      Rst = 1'b1; stk_rstn = 1'b0;
      @(negedge Clk);
      chk("midrst flags", {Dbg_State, Done_A, Done_B, Err_A, Err_B, Stk_Push, Stk_Pop}, 8'h00);
      chk("midrst data", {Rdata_A, Rdata_B, Stk_Data_In}, 12'h000);
      Rst = 1'b0; stk_rstn = 1'b1;
      @(negedge Clk);
      chk("midrst regrant", {Dbg_State, Stk_Push, Stk_Data_In}, {2'd1, 1'b1, 4'd6});
      @(negedge Clk);
      chk("midrst done_a", {Done_A, Done_B, Err_A, Err_B}, 4'b1000);
      @(posedge Clk); #1; Req_A = 1'b0;
      @(negedge Clk);
      @(negedge Clk);
      chk("midrst b issue", {Dbg_State, Stk_Push, Stk_Data_In}, {2'd1, 1'b1, 4'd8});
      @(negedge Clk);
      chk("midrst done_b", {Done_A, Done_B, Err_A, Err_B}, 4'b0100);
      @(posedge Clk); #1; Req_B = 1'b0;
      m_stk.delete();
      m_stk.push_back(4'd6);
      m_stk.push_back(4'd8);
      m_last = 1'b1;

      // random traffic: push-heavy first half, pop-heavy second half
      for (int i = 0; i < 160; i++) begin
         bit           av, bv, aop, bop;
         logic [W-1:0] aw, bw;
         int           th;
         th  = (i < 80) ? 3 : 7;
         av  = 1'($urandom_range(0, 1));
         bv  = av ? 1'($urandom_range(0, 1)) : 1'b1;
         aop = ($urandom_range(0, 9) < th);
         bop = ($urandom_range(0, 9) < th);
         aw  = 4'($urandom_range(0, 15));
         bw  = 4'($urandom_range(0, 15));
         serve(av, aop, aw, bv, bop, bw);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
